// File: rtl/writeback_arbiter.sv
// Shares one register-file write port between the ALU and the load path.
// Loads that lose arbitration wait in a small FIFO that tracks kills and hazards.
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int SIZE  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [$clog2(SIZE)-1:0]  alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [$clog2(SIZE)-1:0]  mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     wr_enable,
    output logic [$clog2(SIZE)-1:0]  wr_rd,
    output logic [31:0]              wr_data,
    input  logic [$clog2(SIZE)-1:0]  rs1,
    input  logic [$clog2(SIZE)-1:0]  rs2,
    output logic                     hazard,
    output logic [2:0]               count
);
    localparam int RD_W  = $clog2(SIZE);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [RD_W-1:0]  ent_rd_q [DEPTH];
    logic [RD_W-1:0]  ent_rd_d [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0]       count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [RD_W-1:0]  wr_rd_q, wr_rd_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic accept, fifo_empty, pop, push, bypass, alu_kill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // mem_ready comes from registered occupancy only, so it never waits on mem_valid.
    assign mem_ready  = (count_q < DEPTH_C);
    assign accept     = mem_valid && mem_ready;
    assign fifo_empty = (count_q == 3'd0);
    assign pop        = !alu_valid && !fifo_empty;
    assign bypass     = !alu_valid && fifo_empty && accept;
    assign push       = accept && !bypass;
    assign alu_kill   = alu_valid && (alu_rd != '0);

    always_comb begin
        valid_d    = valid_q;
        killed_d   = killed_q;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_rd_d    = '0;
        wr_data_d  = '0;

        if (alu_valid) begin
            wr_en_d   = (alu_rd != '0);
            wr_rd_d   = alu_rd;
            wr_data_d = alu_data;
        end else if (pop) begin
            wr_en_d   = !killed_q[head_q] && (ent_rd_q[head_q] != '0);
            wr_rd_d   = ent_rd_q[head_q];
            wr_data_d = ent_data_q[head_q];
        end else if (bypass) begin
            wr_en_d   = (mem_rd != '0);
            wr_rd_d   = mem_rd;
            wr_data_d = mem_data;
        end

        // A newer ALU write makes any pending load to the same register stale.
        if (alu_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && ent_rd_q[i] == alu_rd) killed_d[i] = 1'b1;
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        if (push) begin
            valid_d[tail_q]    = 1'b1;
            killed_d[tail_q]   = alu_kill && (mem_rd == alu_rd);
            ent_rd_d[tail_q]   = mem_rd;
            ent_data_d[tail_q] = mem_data;
            tail_d             = ptr_inc(tail_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !killed_q[i] &&
                ((rs1 != '0 && ent_rd_q[i] == rs1) || (rs2 != '0 && ent_rd_q[i] == rs2)))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            killed_q  <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            killed_q   <= killed_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
        end
    end

    assign wr_enable = wr_en_q;
    assign wr_rd     = wr_rd_q;
    assign wr_data   = wr_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (DEPTH=2): ALU path, collisions, full FIFO,
// kills, rd=0 handling and mid-operation reset.
module tb_writeback_arbiter;
    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wr_enable;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [4:0]  rs1, rs2;
    logic        hazard;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.DEPTH(2), .SIZE(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wr_enable(wr_enable), .wr_rd(wr_rd), .wr_data(wr_data),
        .rs1(rs1), .rs2(rs2), .hazard(hazard), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        rs1 = 5'd7;
        tick(); tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_enable: got %b expected 0", wr_enable); end
        checks++; if (wr_rd !== 5'd0) begin errors++; $display("FAIL reset_wr_rd: got %0d expected 0", wr_rd); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b expected 1", mem_ready); end
        reset = 0;
        rs1 = 0;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hAAAA0001;
        tick();
        checks++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL alu_wr_enable: got %b expected 1", wr_enable); end
        checks++; if (wr_rd !== 5'd5) begin errors++; $display("FAIL alu_wr_rd: got %0d expected 5", wr_rd); end
        checks++; if (wr_data !== 32'hAAAA0001) begin errors++; $display("FAIL alu_wr_data: got %h expected aaaa0001", wr_data); end
        idle_inputs();
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL alu_idle_after: got %b expected 0", wr_enable); end
    endtask

    task automatic test_collision();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h0000_1234;
        rs1 = 5'd7;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", mem_ready); end
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd3 || wr_data !== 32'h33) begin errors++; $display("FAIL coll_alu_write: got en=%b rd=%0d data=%h expected en=1 rd=3 data=33", wr_enable, wr_rd, wr_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL coll_count: got %0d expected 1", count); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL coll_hazard: got %b expected 1", hazard); end
        alu_valid = 0; mem_valid = 0;
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd7 || wr_data !== 32'h1234) begin errors++; $display("FAIL coll_load_write: got en=%b rd=%0d data=%h expected en=1 rd=7 data=1234", wr_enable, wr_rd, wr_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL coll_count_drain: got %0d expected 0", count); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL coll_hazard_clear: got %b expected 0", hazard); end
        idle_inputs();
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL coll_idle: got %b expected 0", wr_enable); end
    endtask

    task automatic test_full();
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA0;
        mem_valid = 1; mem_rd = 5'd1; mem_data = 32'h101;
        tick();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL full_count1: got %0d expected 1", count); end
        alu_rd = 5'd11; alu_data = 32'hA1;
        mem_rd = 5'd2; mem_data = 32'h102;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one: got %b expected 1", mem_ready); end
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL full_count2: got %0d expected 2", count); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", mem_ready); end
        alu_rd = 5'd12; alu_data = 32'hA2;
        mem_rd = 5'd3; mem_data = 32'h103;
        tick();
        checks++; if (count !== 3'd2 || wr_rd !== 5'd12) begin errors++; $display("FAIL full_hold: got count=%0d rd=%0d expected count=2 rd=12", count, wr_rd); end
        alu_valid = 0;
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd1 || wr_data !== 32'h101) begin errors++; $display("FAIL full_drain1: got en=%b rd=%0d data=%h expected en=1 rd=1 data=101", wr_enable, wr_rd, wr_data); end
        checks++; if (count !== 3'd1 || mem_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got count=%0d ready=%b expected count=1 ready=1", count, mem_ready); end
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd2 || wr_data !== 32'h102) begin errors++; $display("FAIL full_drain2: got en=%b rd=%0d data=%h expected en=1 rd=2 data=102", wr_enable, wr_rd, wr_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL full_pop_push_count: got %0d expected 1", count); end
        mem_valid = 0;
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd3 || wr_data !== 32'h103) begin errors++; $display("FAIL full_drain3: got en=%b rd=%0d data=%h expected en=1 rd=3 data=103", wr_enable, wr_rd, wr_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", count); end
        idle_inputs();
        tick();
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL full_idle: got %b expected 0", wr_enable); end
    endtask

    task automatic test_kill();
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
        mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h99;
        rs2 = 5'd9;
        tick();
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL kill_hazard_before: got %b expected 1", hazard); end
        alu_rd = 5'd9; alu_data = 32'h55; mem_valid = 0;
        tick();
        checks++; if (wr_enable !== 1'b1 || wr_rd !== 5'd9 || wr_data !== 32'h55) begin errors++; $display("FAIL kill_alu_write: got en=%b rd=%0d data=%h expected en=1 rd=9 data=55", wr_enable, wr_rd, wr_data); end
        checks++; if (hazard !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL kill_state: got hazard=%b count=%0d expected hazard=0 count=1", hazard, count); end
        alu_valid = 0;
        tick();
        checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL kill_pop_silent: got en=%b count=%0d expected en=0 count=0", wr_enable, count); end
        // Same-cycle kill: load and ALU target the same register together.
        alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
        mem_valid = 1; mem_rd = 5'd6; mem_data = 32'h77;
        rs2 = 0; rs1 = 5'd6;
        tick();
        checks++; if (wr_rd !== 5'd6 || wr_data !== 32'h66 || count !== 3'd1 || hazard !== 1'b0) begin errors++; $display("FAIL kill_same_cycle: got rd=%0d data=%h count=%0d hazard=%b expected rd=6 data=66 count=1 hazard=0", wr_rd, wr_data, count, hazard); end
        idle_inputs();
        tick();
        checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL kill_same_pop: got en=%b count=%0d expected en=0 count=0", wr_enable, count); end
    endtask

    task automatic test_rd_zero();
        mem_valid = 1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        rs1 = 5'd0;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rd0_hazard: got %b expected 0", hazard); end
        tick();
        checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rd0_bypass: got en=%b count=%0d expected en=0 count=0", wr_enable, count); end
        alu_valid = 1; alu_rd = 5'd8; alu_data = 32'h88;
        tick();
        checks++; if (count !== 3'd1 || hazard !== 1'b0) begin errors++; $display("FAIL rd0_deferred: got count=%0d hazard=%b expected count=1 hazard=0", count, hazard); end
        idle_inputs();
        tick();
        checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rd0_pop: got en=%b count=%0d expected en=0 count=0", wr_enable, count); end
    endtask

    task automatic test_mid_reset();
        alu_valid = 1; alu_rd = 5'd20; alu_data = 32'h20;
        mem_valid = 1; mem_rd = 5'd13; mem_data = 32'h13;
        tick();
        alu_rd = 5'd21; mem_rd = 5'd14; mem_data = 32'h14;
        tick();
        checks++; if (count !== 3'd2 || mem_ready !== 1'b0) begin errors++; $display("FAIL mrst_fill: got count=%0d ready=%b expected count=2 ready=0", count, mem_ready); end
        idle_inputs();
        rs1 = 5'd13;
        reset = 1;
        #1;
        checks++; if (count !== 3'd0 || mem_ready !== 1'b1) begin errors++; $display("FAIL mrst_immediate: got count=%0d ready=%b expected count=0 ready=1", count, mem_ready); end
        checks++; if (wr_enable !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL mrst_outputs: got en=%b hazard=%b expected en=0 hazard=0", wr_enable, hazard); end
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_enable !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mrst_stale_%0d: got en=%b count=%0d expected en=0 count=0", i, wr_enable, count); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_collision();
        test_full();
        test_kill();
        test_rd_zero();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
